// File: rtl/rf_write_arbiter_pkg.sv
// Shared pipeline definitions for the register-file write path.
// The write-port bundle is used by WB, the write arbiter and the register file.
package rf_write_arbiter_pkg;

  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NREG = 32;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] wn;
    logic [DW-1:0] d;
  } rf_wr_t;

endpackage

// File: rtl/rf_wr_fifo.sv
// Queue of long-latency results.
// Each entry carries a kill bit so a newer WB write can squash it in place.
module rf_wr_fifo #(
  parameter int DEPTH = 2,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                         clk,
  input  logic                         clr,
  input  logic                         i_push,
  input  logic [AW-1:0]                i_push_wn,
  input  logic [DW-1:0]                i_push_d,
  input  logic                         i_pop,
  input  logic                         i_kill_en,
  input  logic [AW-1:0]                i_kill_wn,
  output logic [$clog2(DEPTH):0]       o_count,
  output logic [AW-1:0]                o_head_wn,
  output logic [DW-1:0]                o_head_d,
  output logic                         o_head_kill,
  output logic [DEPTH-1:0]             o_live_nxt,
  output logic [DEPTH-1:0][AW-1:0]     o_wn_nxt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][AW-1:0] r_wn;
  logic [DW-1:0]            r_d [DEPTH];
  logic [DEPTH-1:0]         r_kill;
  logic [PW-1:0]            r_rd_ptr;
  logic [PW-1:0]            r_wr_ptr;
  logic [CW-1:0]            r_count;

  logic [DEPTH-1:0][AW-1:0] w_wn_nxt;
  logic [DW-1:0]            w_d_nxt [DEPTH];
  logic [DEPTH-1:0]         w_kill_nxt;
  logic [DEPTH-1:0]         w_live_nxt;
  logic [PW-1:0]            w_rd_nxt;
  logic [PW-1:0]            w_wr_nxt;
  logic [CW-1:0]            w_cnt_nxt;
  logic                     w_hit;

  // Slot idx holds a queued entry when its distance from the read pointer is below the count.
  function automatic logic slot_used(input logic [PW-1:0] idx,
                                     input logic [PW-1:0] rd,
                                     input logic [CW-1:0] cnt);
    logic [PW-1:0] off;
    off = idx - rd;
    return ({1'b0, off} < cnt);
  endfunction

  // Next-state for pointers, entries and kill bits, plus the post-edge live mask.
  always_comb begin
    w_rd_nxt   = r_rd_ptr + PW'(i_pop);
    w_wr_nxt   = r_wr_ptr + PW'(i_push);
    w_cnt_nxt  = r_count + CW'(i_push) - CW'(i_pop);
    w_wn_nxt   = r_wn;
    w_kill_nxt = r_kill;
    w_live_nxt = '0;
    w_hit      = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w_d_nxt[i] = r_d[i];
      w_hit = i_kill_en && slot_used(PW'(i), r_rd_ptr, r_count) && (r_wn[i] == i_kill_wn);
      // A same-cycle push is younger than the WB write, so it is never killed.
      if (i_push && (PW'(i) == r_wr_ptr)) begin
        w_wn_nxt[i]   = i_push_wn;
        w_d_nxt[i]    = i_push_d;
        w_kill_nxt[i] = 1'b0;
      end else begin
        w_kill_nxt[i] = r_kill[i] | w_hit;
      end
      w_live_nxt[i] = slot_used(PW'(i), w_rd_nxt, w_cnt_nxt) && !w_kill_nxt[i];
    end
  end

  // FIFO state registers.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_kill   <= '0;
      r_wn     <= '0;
      for (int i = 0; i < DEPTH; i++) r_d[i] <= '0;
    end else begin
      r_rd_ptr <= w_rd_nxt;
      r_wr_ptr <= w_wr_nxt;
      r_count  <= w_cnt_nxt;
      r_kill   <= w_kill_nxt;
      r_wn     <= w_wn_nxt;
      for (int i = 0; i < DEPTH; i++) r_d[i] <= w_d_nxt[i];
    end
  end

  assign o_count     = r_count;
  assign o_head_wn   = r_wn[r_rd_ptr];
  assign o_head_d    = r_d[r_rd_ptr];
  assign o_head_kill = r_kill[r_rd_ptr];
  assign o_live_nxt  = w_live_nxt;
  assign o_wn_nxt    = w_wn_nxt;

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: WB has absolute priority, long-latency results
// drain from a small FIFO into idle cycles, and pend_mask flags their destinations.
module rf_write_arbiter #(
  parameter int DEPTH = 2,
  parameter int AW    = rf_write_arbiter_pkg::AW,
  parameter int DW    = rf_write_arbiter_pkg::DW
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 wb_we,
  input  logic [AW-1:0]        wb_wn,
  input  logic [DW-1:0]        wb_d,
  input  logic                 lu_valid,
  input  logic [AW-1:0]        lu_wn,
  input  logic [DW-1:0]        lu_d,
  output logic                 lu_ready,
  output logic                 we,
  output logic [AW-1:0]        wn,
  output logic [DW-1:0]        d,
  output logic [(1<<AW)-1:0]   pend_mask
);

  import rf_write_arbiter_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic                     w_wb_wr;
  logic                     w_lu_ready;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_head_live;
  logic                     w_kill_en;
  logic [CW-1:0]            w_count;
  logic [AW-1:0]            w_head_wn;
  logic [DW-1:0]            w_head_d;
  logic                     w_head_kill;
  logic [DEPTH-1:0]         w_live_nxt;
  logic [DEPTH-1:0][AW-1:0] w_wn_nxt;
  logic [(1<<AW)-1:0]       w_pend_nxt;
  logic [(1<<AW)-1:0]       r_pend_mask;
  rf_wr_t                   w_sel;

  rf_wr_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fifo (
    .clk         (clk),
    .clr         (clr),
    .i_push      (w_push),
    .i_push_wn   (lu_wn),
    .i_push_d    (lu_d),
    .i_pop       (w_pop),
    .i_kill_en   (w_kill_en),
    .i_kill_wn   (wb_wn),
    .o_count     (w_count),
    .o_head_wn   (w_head_wn),
    .o_head_d    (w_head_d),
    .o_head_kill (w_head_kill),
    .o_live_nxt  (w_live_nxt),
    .o_wn_nxt    (w_wn_nxt)
  );

  // Handshake, pop decision and write-port select; register 0 never counts as a write.
  always_comb begin
    w_wb_wr     = wb_we && (wb_wn != '0);
    w_lu_ready  = !clr && (w_count != CW'(DEPTH));
    w_push      = lu_valid && w_lu_ready && (lu_wn != '0);
    w_head_live = (w_count != '0) && !w_head_kill;
    // Killed heads leave even under WB traffic; live heads only in idle cycles.
    w_pop       = !clr && (w_count != '0) && (w_head_kill || !w_wb_wr);
    w_kill_en   = !clr && w_wb_wr;
    w_sel       = '0;
    if (clr) begin
      w_sel = '0;
    end else if (w_wb_wr) begin
      w_sel.we = 1'b1;
      w_sel.wn = wb_wn;
      w_sel.d  = wb_d;
    end else if (w_head_live) begin
      w_sel.we = 1'b1;
      w_sel.wn = w_head_wn;
      w_sel.d  = w_head_d;
    end else begin
      w_sel = '0;
    end
  end

  // Decode post-edge live entries into a per-register pending mask.
  always_comb begin
    w_pend_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_live_nxt[i]) begin
        w_pend_nxt[w_wn_nxt[i]] = 1'b1;
      end else begin
        w_pend_nxt = w_pend_nxt;
      end
    end
    w_pend_nxt[0] = 1'b0;
  end

  // Pending-write mask register.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_pend_mask <= '0;
    end else begin
      r_pend_mask <= w_pend_nxt;
    end
  end

  assign lu_ready  = w_lu_ready;
  assign we        = w_sel.we;
  assign wn        = w_sel.wn;
  assign d         = w_sel.d;
  assign pend_mask = r_pend_mask;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed self-checking bench for rf_write_arbiter (DEPTH=2, AW=5, DW=32).
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        clr;
  logic        wb_we;
  logic [4:0]  wb_wn;
  logic [31:0] wb_d;
  logic        lu_valid;
  logic [4:0]  lu_wn;
  logic [31:0] lu_d;
  logic        lu_ready;
  logic        we;
  logic [4:0]  wn;
  logic [31:0] d;
  logic [31:0] pend_mask;
  logic [31:0] rf_model [32];

  int checks = 0;
  int errors = 0;

  rf_write_arbiter #(.DEPTH(2), .AW(5), .DW(32)) dut (
    .clk       (clk),
    .clr       (clr),
    .wb_we     (wb_we),
    .wb_wn     (wb_wn),
    .wb_d      (wb_d),
    .lu_valid  (lu_valid),
    .lu_wn     (lu_wn),
    .lu_d      (lu_d),
    .lu_ready  (lu_ready),
    .we        (we),
    .wn        (wn),
    .d         (d),
    .pend_mask (pend_mask)
  );

  always #5 clk = ~clk;

  // Register file fed by the arbiter's write port.
  always @(posedge clk) begin
    if (we) rf_model[wn] <= d;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    clr = 1'b1; wb_we = 1'b1; wb_wn = 5'd5; wb_d = 32'h1; lu_valid = 1'b0; lu_wn = 5'd0; lu_d = 32'h0;
    #1;
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL rst_we got=%0h exp=0", we); end
    checks++; if (lu_ready !== 1'b0) begin errors++; $display("FAIL rst_lu_ready got=%0h exp=0", lu_ready); end
    tick();
    clr = 1'b0; wb_we = 1'b0;
    #1;
    checks++; if (pend_mask !== 32'h0) begin errors++; $display("FAIL idle_pend got=%0h exp=0", pend_mask); end
    checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL idle_lu_ready got=%0h exp=1", lu_ready); end
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL idle_we got=%0h exp=0", we); end
    // Queue two entries behind WB traffic, then reset.
    wb_we = 1'b1; wb_wn = 5'd1; wb_d = 32'h1; lu_valid = 1'b1; lu_wn = 5'd10; lu_d = 32'hA0;
    tick();
    lu_wn = 5'd11; lu_d = 32'hB0;
    tick();
    lu_valid = 1'b0;
    #1;
    checks++; if (pend_mask !== 32'h0000_0C00) begin errors++; $display("FAIL q2_pend got=%0h exp=c00", pend_mask); end
    checks++; if (lu_ready !== 1'b0) begin errors++; $display("FAIL q2_lu_ready got=%0h exp=0", lu_ready); end
    clr = 1'b1; wb_we = 1'b0;
    #1;
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL clr_drain_we got=%0h exp=0", we); end
    tick();
    clr = 1'b0;
    #1;
    checks++; if (pend_mask !== 32'h0) begin errors++; $display("FAIL post_clr_pend got=%0h exp=0", pend_mask); end
    checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL post_clr_lu_ready got=%0h exp=1", lu_ready); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (we !== 1'b0) begin errors++; $display("FAIL post_clr_we[%0d] got=%0h exp=0", i, we); end
      tick();
    end
  endtask

  task automatic test_wb;
    wb_we = 1'b1; wb_wn = 5'd5; wb_d = 32'hDEADBEEF;
    #1;
    checks++; if ({we, wn, d} !== {1'b1, 5'd5, 32'hDEADBEEF})
      begin errors++; $display("FAIL wb_write got=%0h/%0d/%0h exp=1/5/deadbeef", we, wn, d); end
    tick();
    wb_wn = 5'd0;
    #1;
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL wb_r0_we got=%0h exp=0", we); end
    tick();
    wb_we = 1'b0;
  endtask

  task automatic test_lu;
    lu_valid = 1'b1; lu_wn = 5'd7; lu_d = 32'h12;
    #1;
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL lu_push_we got=%0h exp=0", we); end
    tick();
    lu_valid = 1'b0;
    #1;
    checks++; if (pend_mask !== 32'h0000_0080) begin errors++; $display("FAIL lu_pend got=%0h exp=80", pend_mask); end
    checks++; if ({we, wn, d} !== {1'b1, 5'd7, 32'h12})
      begin errors++; $display("FAIL lu_drain got=%0h/%0d/%0h exp=1/7/12", we, wn, d); end
    tick();
    checks++; if (pend_mask !== 32'h0) begin errors++; $display("FAIL lu_pend_clr got=%0h exp=0", pend_mask); end
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL lu_after_we got=%0h exp=0", we); end
  endtask

  task automatic test_full;
    wb_we = 1'b1; wb_wn = 5'd1; wb_d = 32'h111;
    lu_valid = 1'b1; lu_wn = 5'd3; lu_d = 32'h33;
    tick();
    lu_wn = 5'd4; lu_d = 32'h44;
    #1;
    checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL full_ready1 got=%0h exp=1", lu_ready); end
    tick();
    lu_wn = 5'd6; lu_d = 32'h66;
    for (int i = 0; i < 2; i++) begin
      checks++; if (lu_ready !== 1'b0) begin errors++; $display("FAIL full_held[%0d] got=%0h exp=0", i, lu_ready); end
      checks++; if ({we, wn} !== {1'b1, 5'd1}) begin errors++; $display("FAIL full_wb[%0d] got=%0h/%0d exp=1/1", i, we, wn); end
      tick();
    end
    checks++; if (pend_mask !== 32'h0000_0018) begin errors++; $display("FAIL full_pend got=%0h exp=18", pend_mask); end
    wb_we = 1'b0;
    #1;
    checks++; if ({we, wn, d} !== {1'b1, 5'd3, 32'h33})
      begin errors++; $display("FAIL rel_w3 got=%0h/%0d/%0h exp=1/3/33", we, wn, d); end
    checks++; if (lu_ready !== 1'b0) begin errors++; $display("FAIL rel_ready0 got=%0h exp=0", lu_ready); end
    tick();
    checks++; if ({we, wn, d} !== {1'b1, 5'd4, 32'h44})
      begin errors++; $display("FAIL rel_w4 got=%0h/%0d/%0h exp=1/4/44", we, wn, d); end
    checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL rel_ready1 got=%0h exp=1", lu_ready); end
    tick();
    lu_valid = 1'b0;
    #1;
    checks++; if (pend_mask !== 32'h0000_0040) begin errors++; $display("FAIL rel_pend6 got=%0h exp=40", pend_mask); end
    checks++; if ({we, wn, d} !== {1'b1, 5'd6, 32'h66})
      begin errors++; $display("FAIL rel_w6 got=%0h/%0d/%0h exp=1/6/66", we, wn, d); end
    tick();
    checks++; if ({we, pend_mask} !== {1'b0, 32'h0}) begin errors++; $display("FAIL rel_idle got=%0h/%0h exp=0/0", we, pend_mask); end
  endtask

  task automatic test_waw;
    wb_we = 1'b1; wb_wn = 5'd1; wb_d = 32'h1;
    lu_valid = 1'b1; lu_wn = 5'd9; lu_d = 32'hAA;
    tick();
    lu_valid = 1'b0;
    wb_wn = 5'd9; wb_d = 32'hBB;
    #1;
    checks++; if (pend_mask !== 32'h0000_0200) begin errors++; $display("FAIL waw_pend9 got=%0h exp=200", pend_mask); end
    checks++; if ({we, wn, d} !== {1'b1, 5'd9, 32'hBB})
      begin errors++; $display("FAIL waw_wb got=%0h/%0d/%0h exp=1/9/bb", we, wn, d); end
    tick();
    wb_we = 1'b0;
    #1;
    checks++; if (pend_mask !== 32'h0) begin errors++; $display("FAIL waw_pend_clr got=%0h exp=0", pend_mask); end
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL waw_killed_we got=%0h exp=0", we); end
    tick();
    checks++; if ({we, lu_ready} !== 2'b01) begin errors++; $display("FAIL waw_empty got=%0h/%0h exp=0/1", we, lu_ready); end
    checks++; if (rf_model[9] !== 32'hBB) begin errors++; $display("FAIL waw_rf9 got=%0h exp=bb", rf_model[9]); end
    // Same-cycle push to the WB register survives as the younger value.
    wb_we = 1'b1; wb_wn = 5'd12; wb_d = 32'h11;
    lu_valid = 1'b1; lu_wn = 5'd12; lu_d = 32'hCC;
    tick();
    wb_we = 1'b0; lu_valid = 1'b0;
    #1;
    checks++; if (pend_mask !== 32'h0000_1000) begin errors++; $display("FAIL same_pend got=%0h exp=1000", pend_mask); end
    checks++; if ({we, wn, d} !== {1'b1, 5'd12, 32'hCC})
      begin errors++; $display("FAIL same_drain got=%0h/%0d/%0h exp=1/12/cc", we, wn, d); end
    tick();
    checks++; if (rf_model[12] !== 32'hCC) begin errors++; $display("FAIL same_rf12 got=%0h exp=cc", rf_model[12]); end
  endtask

  task automatic test_zero;
    lu_valid = 1'b1; lu_wn = 5'd0; lu_d = 32'h55;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if ({lu_ready, we} !== 2'b10) begin errors++; $display("FAIL zero_push[%0d] got=%0h/%0h exp=1/0", i, lu_ready, we); end
      tick();
    end
    lu_valid = 1'b0;
    #1;
    checks++; if ({we, pend_mask} !== {1'b0, 32'h0}) begin errors++; $display("FAIL zero_after got=%0h/%0h exp=0/0", we, pend_mask); end
    // wb_we to register 0 leaves the port free for the FIFO.
    wb_we = 1'b1; wb_wn = 5'd2; wb_d = 32'h2;
    lu_valid = 1'b1; lu_wn = 5'd13; lu_d = 32'hD13;
    tick();
    lu_valid = 1'b0; wb_wn = 5'd0; wb_d = 32'h77;
    #1;
    checks++; if ({we, wn, d} !== {1'b1, 5'd13, 32'hD13})
      begin errors++; $display("FAIL wb0_drain got=%0h/%0d/%0h exp=1/13/d13", we, wn, d); end
    tick();
    wb_we = 1'b0;
    #1;
    checks++; if ({we, pend_mask} !== {1'b0, 32'h0}) begin errors++; $display("FAIL wb0_after got=%0h/%0h exp=0/0", we, pend_mask); end
  endtask

  initial begin
    clr = 1'b1; wb_we = 1'b0; wb_wn = 5'd0; wb_d = 32'h0;
    lu_valid = 1'b0; lu_wn = 5'd0; lu_d = 32'h0;
    tick();
    test_reset();
    test_wb();
    test_lu();
    test_full();
    test_waw();
    test_zero();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
